demux_deser_two: RTL and testbench

DEMUX_DESER_TWO -- requirements
Module: demux_deser_two

---
 rtl/demux_deser_two.sv | 168 ++++++++++++++++
 tb/tb_demux_deser_two.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_deser_two.sv
// Two-channel LSB-first deserializer behind a 1-bit demux. Each channel has a
// one-word holding register with an overrun pulse. Define DEMUX_DESER_OVRCNT_EN
// to add the saturating per-channel overrun counters ch0_ovr_cnt/ch1_ovr_cnt.
module demux_deser_two #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             sel,
   input  logic             y0,
   input  logic             y1,
   input  logic             flush,
   output logic [WIDTH-1:0] ch0_data,
   output logic [WIDTH-1:0] ch1_data,
   output logic             ch0_valid,
   output logic             ch1_valid,
   input  logic             ch0_ready,
   input  logic             ch1_ready,
   output logic             ch0_ovr,
   output logic             ch1_ovr
`ifdef DEMUX_DESER_OVRCNT_EN
   ,
   output logic [3:0]       ch0_ovr_cnt,
   output logic [3:0]       ch1_ovr_cnt
`endif
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e           state_q  [2];
   state_e           state_d  [2];
   logic [CW-1:0]    cnt_q    [2];
   logic [CW-1:0]    cnt_d    [2];
   logic [WIDTH-1:0] shreg_q  [2];
   logic [WIDTH-1:0] shreg_d  [2];
   logic [WIDTH-1:0] data_q   [2];
   logic [WIDTH-1:0] data_d   [2];
   logic             ovr_q    [2];
   logic             ovr_d    [2];
   logic             complete [2];
   logic [WIDTH-1:0] word     [2];
   logic             load     [2];
   logic             valid    [2];
   logic             ready    [2];
   logic             bit_in;

   assign bit_in   = sel ? y1 : y0;
   assign ready[0] = ch0_ready;
   assign ready[1] = ch1_ready;

   // Bit assembly; flush wins over a bit sampled on the same edge.
   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         cnt_d[i]             = cnt_q[i];
         shreg_d[i]           = shreg_q[i];
         complete[i]          = 1'b0;
         word[i]              = shreg_q[i];
         word[i][WIDTH-1]     = bit_in;
         if (flush) begin
            cnt_d[i]   = '0;
            shreg_d[i] = '0;
         end else if (in_valid && (sel == i[0])) begin
            if (cnt_q[i] == LAST) begin
               cnt_d[i]    = '0;
               shreg_d[i]  = '0;
               complete[i] = 1'b1;
            end else begin
               cnt_d[i]             = cnt_q[i] + CW'(1);
               shreg_d[i][cnt_q[i]] = bit_in;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 2; i++) begin
            state_q[i] <= EMPTY;
         end
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            state_q[i] <= state_d[i];
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         state_d[i] = state_q[i];
         case (state_q[i])
            EMPTY:   if (complete[i]) state_d[i] = FULL;
            FULL:    if (ready[i] && !complete[i]) state_d[i] = EMPTY;
            default: state_d[i] = EMPTY;
         endcase
      end
   end

   // A word completing while FULL loads only if the held word leaves on the same edge.
   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         valid[i]  = (state_q[i] == FULL);
         load[i]   = complete[i] && ((state_q[i] == EMPTY) || ready[i]);
         ovr_d[i]  = complete[i] && (state_q[i] == FULL) && !ready[i];
         data_d[i] = load[i] ? word[i] : data_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 2; i++) begin
            cnt_q[i]   <= '0;
            shreg_q[i] <= '0;
            data_q[i]  <= '0;
            ovr_q[i]   <= 1'b0;
         end
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            cnt_q[i]   <= cnt_d[i];
            shreg_q[i] <= shreg_d[i];
            data_q[i]  <= data_d[i];
            ovr_q[i]   <= ovr_d[i];
         end
      end
   end

   assign ch0_data  = data_q[0];
   assign ch1_data  = data_q[1];
   assign ch0_valid = valid[0];
   assign ch1_valid = valid[1];
   assign ch0_ovr   = ovr_q[0];
   assign ch1_ovr   = ovr_q[1];

`ifdef DEMUX_DESER_OVRCNT_EN
   logic [3:0] ovrcnt_q [2];
   logic [3:0] ovrcnt_d [2];

   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         ovrcnt_d[i] = ovrcnt_q[i];
         if (flush) begin
            ovrcnt_d[i] = '0;
         end else if (ovr_d[i] && (ovrcnt_q[i] != 4'hF)) begin
            ovrcnt_d[i] = ovrcnt_q[i] + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 2; i++) begin
            ovrcnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            ovrcnt_q[i] <= ovrcnt_d[i];
         end
      end
   end

   assign ch0_ovr_cnt = ovrcnt_q[0];
   assign ch1_ovr_cnt = ovrcnt_q[1];
`endif

endmodule

// File: tb/tb_demux_deser_two.sv
// Directed bench for demux_deser_two (WIDTH=8): expected words are queued per
// channel as they are sent and popped whenever a channel hands a word over.
module tb_demux_deser_two;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         sel;
   logic         y0;
   logic         y1;
   logic         flush;
   logic [W-1:0] ch0_data;
   logic [W-1:0] ch1_data;
   logic         ch0_valid;
   logic         ch1_valid;
   logic         ch0_ready;
   logic         ch1_ready;
   logic         ch0_ovr;
   logic         ch1_ovr;
`ifdef DEMUX_DESER_OVRCNT_EN
   logic [3:0]   ch0_ovr_cnt;
   logic [3:0]   ch1_ovr_cnt;
`endif

   int unsigned  compared   = 0;
   int unsigned  mismatched = 0;
   logic [W-1:0] q0 [$];
   logic [W-1:0] q1 [$];

   always #5 clk = ~clk;

   demux_deser_two #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .sel       (sel),
      .y0        (y0),
      .y1        (y1),
      .flush     (flush),
      .ch0_data  (ch0_data),
      .ch1_data  (ch1_data),
      .ch0_valid (ch0_valid),
      .ch1_valid (ch1_valid),
      .ch0_ready (ch0_ready),
      .ch1_ready (ch1_ready),
      .ch0_ovr   (ch0_ovr),
      .ch1_ovr   (ch1_ovr)
`ifdef DEMUX_DESER_OVRCNT_EN
      ,
      .ch0_ovr_cnt (ch0_ovr_cnt),
      .ch1_ovr_cnt (ch1_ovr_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Consumer side: a word is handed over on the edge following valid&&ready.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (ch0_valid && ch0_ready) begin
            check("ch0_sb_nonempty", {31'd0, q0.size() != 0}, 32'd1);
            if (q0.size() != 0) check("ch0_sb_data", {24'd0, ch0_data}, {24'd0, q0.pop_front()});
         end
         if (ch1_valid && ch1_ready) begin
            check("ch1_sb_nonempty", {31'd0, q1.size() != 0}, 32'd1);
            if (q1.size() != 0) check("ch1_sb_data", {24'd0, ch1_data}, {24'd0, q1.pop_front()});
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the sampling edge.
   task automatic send_bit(input logic s, input logic b);
      in_valid = 1'b1;
      sel      = s;
      if (s) begin y1 = b; y0 = 1'($urandom); end
      else   begin y0 = b; y1 = 1'($urandom); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      sel      = 1'($urandom);
      y0       = 1'($urandom);
      y1       = 1'($urandom);
   endtask

   task automatic send_word(input logic s, input logic [W-1:0] w, input int unsigned nbits);
      for (int unsigned i = 0; i < nbits; i++) send_bit(s, w[i]);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin @(posedge clk); #1; end
   endtask

   initial begin
      logic [W-1:0] w;
      rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; y0 = 1'b0; y1 = 1'b0;
      flush = 1'b0; ch0_ready = 1'b0; ch1_ready = 1'b0;
      #12;
      check("rst_ch0_valid", {31'd0, ch0_valid}, 32'd0);
      check("rst_ch1_valid", {31'd0, ch1_valid}, 32'd0);
      check("rst_ch0_data", {24'd0, ch0_data}, 32'd0);
      check("rst_ch1_ovr", {31'd0, ch1_ovr}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1,0,1,1,0,0,1,0 LSB-first on ch0
      w = 8'b0100_1101;
      send_word(1'b0, w, 8);
      check("basic_ch0_valid", {31'd0, ch0_valid}, 32'd1);
      check("basic_ch0_data", {24'd0, ch0_data}, 32'h4D);
      check("basic_ch1_valid", {31'd0, ch1_valid}, 32'd0);
      q0.push_back(8'h4D);
      ch0_ready = 1'b1; idle(1); ch0_ready = 1'b0;
      check("drain_ch0_valid", {31'd0, ch0_valid}, 32'd0);

      // interleaved channels, unselected y randomised inside send_bit
      for (int unsigned i = 0; i < W; i++) begin
         w = 8'h3C; send_bit(1'b0, w[i]);
         w = 8'hC5; send_bit(1'b1, w[i]);
      end
      check("intl_ch0_data", {24'd0, ch0_data}, 32'h3C);
      check("intl_ch1_data", {24'd0, ch1_data}, 32'hC5);
      check("intl_ch0_valid", {31'd0, ch0_valid}, 32'd1);
      check("intl_ch1_valid", {31'd0, ch1_valid}, 32'd1);
      q0.push_back(8'h3C); q1.push_back(8'hC5);
      ch0_ready = 1'b1; ch1_ready = 1'b1; idle(1); ch0_ready = 1'b0; ch1_ready = 1'b0;

      // overrun: second word dropped, held word kept, one-cycle pulse
      send_word(1'b0, 8'h81, 8);
      check("ovr_pre", {31'd0, ch0_ovr}, 32'd0);
      send_word(1'b0, 8'h7E, 8);
      check("ovr_pulse", {31'd0, ch0_ovr}, 32'd1);
      check("ovr_hold_data", {24'd0, ch0_data}, 32'h81);
      check("ovr_ch1_quiet", {31'd0, ch1_ovr}, 32'd0);
      idle(1);
      check("ovr_pulse_end", {31'd0, ch0_ovr}, 32'd0);
      check("ovr_hold_data2", {24'd0, ch0_data}, 32'h81);
      q0.push_back(8'h81);
      ch0_ready = 1'b1; idle(1); ch0_ready = 1'b0;

      // ready on the completing edge: no bubble
      send_word(1'b0, 8'h12, 8);
      send_word(1'b0, 8'h34, 7);
      q0.push_back(8'h12); q0.push_back(8'h34);
      ch0_ready = 1'b1;
      w = 8'h34; send_bit(1'b0, w[7]);
      check("nobub_valid", {31'd0, ch0_valid}, 32'd1);
      check("nobub_data", {24'd0, ch0_data}, 32'h34);
      check("nobub_no_ovr", {31'd0, ch0_ovr}, 32'd0);
      idle(1); ch0_ready = 1'b0;
      check("nobub_drained", {31'd0, ch0_valid}, 32'd0);

      // flush with ch0 holding a word
      send_word(1'b0, 8'h5A, 8);
      send_word(1'b1, 8'hFF, 5);
      flush = 1'b1; in_valid = 1'b1; sel = 1'b1; y1 = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      check("flush_ch0_valid", {31'd0, ch0_valid}, 32'd1);
      check("flush_ch0_data", {24'd0, ch0_data}, 32'h5A);
      check("flush_ch1_empty", {31'd0, ch1_valid}, 32'd0);
      send_word(1'b1, 8'hA5, 8);
      check("flush_ch1_data", {24'd0, ch1_data}, 32'hA5);
      q0.push_back(8'h5A); q1.push_back(8'hA5);
      ch0_ready = 1'b1; ch1_ready = 1'b1; idle(1); ch0_ready = 1'b0; ch1_ready = 1'b0;

      // in_valid=0 gaps with random sel/y must not disturb assembly
      w = 8'h96;
      for (int unsigned i = 0; i < W; i++) begin
         send_bit(1'b0, w[i]);
         idle(i % 3);
      end
      check("gap_ch0_data", {24'd0, ch0_data}, 32'h96);
      q0.push_back(8'h96);
      ch0_ready = 1'b1; idle(1); ch0_ready = 1'b0;

      // asynchronous reset between edges, mid-word, with ch1 holding
      send_word(1'b1, 8'h44, 8);
      send_word(1'b0, 8'hFF, 3);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ch1_valid", {31'd0, ch1_valid}, 32'd0);
      check("arst_ch1_data", {24'd0, ch1_data}, 32'd0);
      check("arst_ch0_data", {24'd0, ch0_data}, 32'd0);
      #1 rst_n = 1'b1;
      send_word(1'b0, 8'hE7, 8);
      check("arst_after_data", {24'd0, ch0_data}, 32'hE7);
      check("arst_after_valid", {31'd0, ch0_valid}, 32'd1);
      q0.push_back(8'hE7);
      ch0_ready = 1'b1; idle(1); ch0_ready = 1'b0;

`ifdef DEMUX_DESER_OVRCNT_EN
      send_word(1'b0, 8'h01, 8);
      for (int unsigned k = 0; k < 17; k++) send_word(1'b0, 8'(k), 8);
      check("ovrcnt_sat", {28'd0, ch0_ovr_cnt}, 32'd15);
      check("ovrcnt_ch1", {28'd0, ch1_ovr_cnt}, 32'd0);
      flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
      check("ovrcnt_flush", {28'd0, ch0_ovr_cnt}, 32'd0);
      q0.push_back(8'h01);
      ch0_ready = 1'b1; idle(1); ch0_ready = 1'b0;
`endif

      idle(2);
      check("sb_ch0_empty", q0.size(), 32'd0);
      check("sb_ch1_empty", q1.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
